tcm_boot_checker: RTL and testbench

Synthesizable TCM boot-and-check sequencer for RISC-V core regression runs. Zero-fills the TCM, streams a program image into it and holds the core in reset until loading completes. It then releases the core, runs a cycle watchdog, and on the core's finish strobe compares N_CH tapped result registers against expected values. Sits between the image source/bench, the TCM write port, and the core's reset and CSR finish flag.

---
 rtl/tcm_boot_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_tcm_boot_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_boot_checker.sv
// -----------------------------------------------------------------------------
// tcm_boot_checker
//
// Boot-and-check sequencer for core regression runs. The block optionally
// zero-fills the TCM, then streams a program image into it while holding the
// core in reset. After a short reset hold it releases the core and runs a
// cycle watchdog. On the core's finish flag it compares N_CH tapped result
// registers against the expected values. Sequence:
//   CLEAR -> LOAD -> HOLD -> RUN -> CHECK -> DONE
//
// Optional feature (compile-time macro):
//   BOOT_CHK_CLEAR_EN  defined   : CLEAR zero-fills all DEPTH words before LOAD.
//                      undefined : reset enters LOAD directly and unwritten
//                                  TCM words keep their previous contents.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   img_valid_i      image word valid
//   img_data_i       image word
//   img_last_i       last image word (qualified by valid & ready)
//   img_ready_o      image word accepted this cycle
//   mem_wr_o         TCM write strobe
//   mem_addr_o       TCM word address
//   mem_data_o       TCM write data
//   core_rst_o       core reset, active-high
//   finish_i         core finish flag (level), only honoured in RUN
//   result_i         tapped result registers, channel 0 in the LSBs
//   expect_i         expected values, static during a run
//   check_mask_i     per-channel compare enable
//   done_o           sequence complete (sticky until rst)
//   pass_o / fail_o  verdict; never both set
//   timeout_o        watchdog expired
//   fail_ch_o        per-channel mismatch flags
//   img_trunc_o      image was longer than DEPTH words
//   cycles_o         RUN cycle count (saturating)
// All outputs are registered.
// -----------------------------------------------------------------------------
module tcm_boot_checker #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 131072,
    parameter int N_CH     = 2,
    parameter int CYC_W    = 32,
    parameter int TIMEOUT  = 1000000,
    parameter int RST_HOLD = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   img_valid_i,
    input  logic [DATA_W-1:0]      img_data_i,
    input  logic                   img_last_i,
    output logic                   img_ready_o,
    output logic                   mem_wr_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic                   core_rst_o,
    input  logic                   finish_i,
    input  logic [N_CH*DATA_W-1:0] result_i,
    input  logic [N_CH*DATA_W-1:0] expect_i,
    input  logic [N_CH-1:0]        check_mask_i,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [N_CH-1:0]        fail_ch_o,
    output logic                   img_trunc_o,
    output logic [CYC_W-1:0]       cycles_o
);

    typedef enum logic [2:0] {CLEAR, LOAD, HOLD, RUN, CHECK, DONE} state_t;

`ifdef BOOT_CHK_CLEAR_EN
    localparam state_t START_STATE = CLEAR;
`else
    localparam state_t START_STATE = LOAD;
`endif

    localparam int                HOLD_W       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_HOLD - 1);
    // Only meaningful when TIMEOUT != 0; every use is guarded by that test.
    localparam logic [CYC_W-1:0]  TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;      // clear / load write pointer
    logic [HOLD_W-1:0]   hold_q, hold_d;      // core reset hold counter

    logic                img_ready_d, mem_wr_d, core_rst_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_data_d;
    logic                done_d, pass_d, fail_d, timeout_d, trunc_d;
    logic [N_CH-1:0]     fail_ch_d;
    logic [CYC_W-1:0]    cycles_d;

    logic                accept;
    logic [N_CH-1:0]     mismatch;

    // img_ready_o is only ever high in LOAD, so this is a LOAD handshake.
    assign accept = img_valid_i & img_ready_o;

    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < N_CH; i++) begin
            mismatch[i] = check_mask_i[i] &
                          (result_i[i*DATA_W +: DATA_W] != expect_i[i*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_o;
        mem_data_d = mem_data_o;
        done_d     = done_o;
        pass_d     = pass_o;
        fail_d     = fail_o;
        timeout_d  = timeout_o;
        fail_ch_d  = fail_ch_o;
        trunc_d    = img_trunc_o;
        cycles_d   = cycles_o;

        case (state_q)
`ifdef BOOT_CHK_CLEAR_EN
            CLEAR: begin
                mem_wr_d   = 1'b1;
                mem_addr_d = addr_q;
                mem_data_d = '0;
                if (addr_q == LAST_ADDR) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
`endif
            LOAD: begin
                if (accept) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = img_data_i;
                    addr_d     = addr_q + ADDR_W'(1);
                    // A full TCM without last ends the load and flags truncation.
                    if (img_last_i || (addr_q == LAST_ADDR)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        trunc_d = ~img_last_i;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                // Finish takes priority over a watchdog expiry in the same cycle.
                if (finish_i) begin
                    state_d = CHECK;
                end else if ((TIMEOUT != 0) && (cycles_o == TIMEOUT_LAST)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    done_d    = 1'b1;
                end else if (cycles_o != '1) begin
                    cycles_d = cycles_o + CYC_W'(1);
                end
            end
            CHECK: begin
                fail_ch_d = mismatch;
                pass_d    = ~|mismatch;
                fail_d    = |mismatch;
                done_d    = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                // Everything holds until rst.
            end
            default: begin
                state_d = START_STATE;
            end
        endcase

        // Registered strobes follow the state being entered.
        img_ready_d = (state_d == LOAD);
        core_rst_d  = ~((state_d == RUN) || (state_d == CHECK));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= START_STATE;
            addr_q      <= '0;
            hold_q      <= '0;
            img_ready_o <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            core_rst_o  <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
            fail_ch_o   <= '0;
            img_trunc_o <= 1'b0;
            cycles_o    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            img_ready_o <= img_ready_d;
            mem_wr_o    <= mem_wr_d;
            mem_addr_o  <= mem_addr_d;
            mem_data_o  <= mem_data_d;
            core_rst_o  <= core_rst_d;
            done_o      <= done_d;
            pass_o      <= pass_d;
            fail_o      <= fail_d;
            timeout_o   <= timeout_d;
            fail_ch_o   <= fail_ch_d;
            img_trunc_o <= trunc_d;
            cycles_o    <= cycles_d;
        end
    end

endmodule

// File: tb/tb_tcm_boot_checker.sv
// -----------------------------------------------------------------------------
// tb_tcm_boot_checker
//
// Scoreboard bench for tcm_boot_checker. Each run pushes the expected TCM
// write sequence and the expected verdict into queues; an independent monitor
// pops and compares whenever the DUT writes or raises done_o. The expected
// values come from a plain model of the boot/check rules. The bench follows
// BOOT_CHK_CLEAR_EN so it predicts the zero-fill when the feature is built in.
// -----------------------------------------------------------------------------
module tb_tcm_boot_checker;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 16;
    localparam int N_CH     = 2;
    localparam int CYC_W    = 16;
    localparam int TIMEOUT  = 120;
    localparam int RST_HOLD = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   img_valid_i;
    logic [DATA_W-1:0]      img_data_i;
    logic                   img_last_i;
    logic                   img_ready_o;
    logic                   mem_wr_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_data_o;
    logic                   core_rst_o;
    logic                   finish_i;
    logic [N_CH*DATA_W-1:0] result_i;
    logic [N_CH*DATA_W-1:0] expect_i;
    logic [N_CH-1:0]        check_mask_i;
    logic                   done_o;
    logic                   pass_o;
    logic                   fail_o;
    logic                   timeout_o;
    logic [N_CH-1:0]        fail_ch_o;
    logic                   img_trunc_o;
    logic [CYC_W-1:0]       cycles_o;

    tcm_boot_checker #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .N_CH    (N_CH),
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .img_valid_i (img_valid_i),
        .img_data_i  (img_data_i),
        .img_last_i  (img_last_i),
        .img_ready_o (img_ready_o),
        .mem_wr_o    (mem_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .core_rst_o  (core_rst_o),
        .finish_i    (finish_i),
        .result_i    (result_i),
        .expect_i    (expect_i),
        .check_mask_i(check_mask_i),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .fail_ch_o   (fail_ch_o),
        .img_trunc_o (img_trunc_o),
        .cycles_o    (cycles_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        bit            pass;
        bit            fail;
        bit            tout;
        bit            trunc;
        bit [N_CH-1:0] fch;
        int            cycles;
    } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Verdict from the rules: watchdog wins unless finish arrives by RUN
    // cycle TIMEOUT-1; otherwise compare every enabled channel.
    function automatic res_t model(input int k, input logic [N_CH-1:0] mask,
                                   input logic [N_CH*DATA_W-1:0] res,
                                   input logic [N_CH*DATA_W-1:0] exp, input bit trunc);
        res_t m;
        m.trunc = trunc;
        m.fch   = '0;
        if (TIMEOUT != 0 && (k < 0 || k >= TIMEOUT)) begin
            m.tout   = 1'b1;
            m.fail   = 1'b1;
            m.pass   = 1'b0;
            m.cycles = TIMEOUT - 1;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (mask[ch] && (res[ch*DATA_W +: DATA_W] != exp[ch*DATA_W +: DATA_W]))
                    m.fch[ch] = 1'b1;
            end
            m.tout   = 1'b0;
            m.pass   = (m.fch == '0);
            m.fail   = !m.pass;
            m.cycles = k;
        end
        return m;
    endfunction

    // Monitor: pops expectations as the DUT presents writes and verdicts.
    bit done_q = 1'b0;
    initial begin
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (mem_wr_o) begin
                check("write_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(mem_addr_o), 64'(w.addr));
                    check("wr_data", 64'(mem_data_o), 64'(w.data));
                end
            end
            if (done_o && !done_q) begin
                check("verdict_expected", 64'(exp_res.size() > 0), 64'd1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    check("done_pass",    64'(pass_o),      64'(r.pass));
                    check("done_fail",    64'(fail_o),      64'(r.fail));
                    check("done_timeout", 64'(timeout_o),   64'(r.tout));
                    check("done_fail_ch", 64'(fail_ch_o),   64'(r.fch));
                    check("done_trunc",   64'(img_trunc_o), 64'(r.trunc));
                    check("done_cycles",  64'(cycles_o),    64'(r.cycles));
                    check("done_core_rst", 64'(core_rst_o), 64'd1);
                end
            end
            done_q = done_o;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst         = 1'b1;
        img_valid_i = 1'b0;
        img_last_i  = 1'b0;
        finish_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_flags", 64'({img_ready_o, mem_wr_o, done_o, pass_o, fail_o,
                                  timeout_o, fail_ch_o, img_trunc_o}), 64'd0);
        check("reset_core_rst", 64'(core_rst_o), 64'd1);
        check("reset_cycles",   64'(cycles_o),   64'd0);
        check("reset_mem_bus",  64'({mem_addr_o, mem_data_o}), 64'd0);
        exp_wr.delete();
        exp_res.delete();
    endtask

    // One boot/run/check sequence. stall: 0 always valid, 1 valid every other
    // cycle, 2 random. k: RUN cycle at which finish rises (-1 = never).
    // abort_at >= 0 resets the DUT that many cycles into RUN.
    task automatic run_case(input int len, input bit has_last, input int stall,
                            input logic [N_CH-1:0] mask,
                            input logic [N_CH*DATA_W-1:0] res,
                            input logic [N_CH*DATA_W-1:0] exp,
                            input int k, input int abort_at);
        logic [DATA_W-1:0] img [0:31];
        int  idx, acc_cyc, rel_cyc, budget, target, j, n_wr;
        bit  released;
        bit  drv_valid;
        res_t m;
        wr_t  w;

        for (int i = 0; i < len; i++) img[i] = $urandom;
        result_i     = res;
        expect_i     = exp;
        check_mask_i = mask;
        apply_reset();

`ifdef BOOT_CHK_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) begin
            w.addr = a;
            w.data = '0;
            exp_wr.push_back(w);
        end
`endif
        n_wr = (len < DEPTH) ? len : DEPTH;
        for (int i = 0; i < n_wr; i++) begin
            w.addr = i;
            w.data = img[i];
            exp_wr.push_back(w);
        end
        target = has_last ? len : DEPTH;
        m = model(k, mask, res, exp, !has_last);
        if (abort_at < 0) exp_res.push_back(m);

        @(negedge clk);
        rst      = 1'b0;
        idx      = 0;
        acc_cyc  = -1;
        rel_cyc  = -1;
        released = 1'b0;
        budget   = 400;
        while (!released && budget > 0) begin
            @(negedge clk);
            budget--;
            if (!core_rst_o) begin
                released = 1'b1;
                rel_cyc  = cyc;
            end else begin
                if (acc_cyc >= 0) check("ready_low_after_load", 64'(img_ready_o), 64'd0);
                if (idx < len) begin
                    case (stall)
                        0:       drv_valid = 1'b1;
                        1:       drv_valid = (cyc % 2 == 0);
                        default: drv_valid = 1'($urandom_range(0, 1));
                    endcase
                    img_valid_i = drv_valid;
                    img_data_i  = img[idx];
                    img_last_i  = has_last && (idx == len - 1);
                    if (drv_valid && img_ready_o) begin
                        idx++;
                        if (idx == target) acc_cyc = cyc;
                    end
                end else begin
                    img_valid_i = 1'b0;
                    img_last_i  = 1'b0;
                end
                // finish is meaningless before RUN and must be ignored.
                finish_i = 1'($urandom_range(0, 1));
            end
        end
        img_valid_i = 1'b0;
        img_last_i  = 1'b0;
        check("core_release_seen", 64'(released), 64'd1);
        if (!released) return;
        check("release_latency", 64'(rel_cyc - acc_cyc), 64'(RST_HOLD + 1));
        check("run_starts_at_zero", 64'(cycles_o), 64'd0);

        if (abort_at >= 0) begin
            finish_i = 1'b0;
            repeat (abort_at) @(negedge clk);
            check("cycles_before_abort", 64'(cycles_o), 64'(abort_at));
            apply_reset();
            return;
        end

        finish_i = (k == 0);
        j        = 0;
        budget   = TIMEOUT + 60;
        while (budget > 0) begin
            @(negedge clk);
            if (done_o) break;
            budget--;
            j++;
            if (j == k) finish_i = 1'b1;
        end
        check("done_seen", 64'(done_o), 64'd1);

        // DONE must hold regardless of finish_i activity.
        repeat (3) begin
            @(negedge clk);
            finish_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("held_cycles",  64'(cycles_o), 64'(m.cycles));
        check("held_verdict", 64'({done_o, core_rst_o, pass_o, fail_o}),
              64'({1'b1, 1'b1, m.pass, m.fail}));
        check("writes_all_seen",   64'(exp_wr.size()),  64'd0);
        check("verdicts_all_seen", 64'(exp_res.size()), 64'd0);
    endtask

    initial begin
        logic [N_CH*DATA_W-1:0] e, r;
        int len, k, sel;
        bit trunc;

        rst          = 1'b1;
        img_valid_i  = 1'b0;
        img_data_i   = '0;
        img_last_i   = 1'b0;
        finish_i     = 1'b0;
        result_i     = '0;
        expect_i     = '0;
        check_mask_i = '0;

        // Directed scenarios.
        run_case(4, 1, 0, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, 100, -1);
        run_case(4, 1, 0, 2'b11, {32'h5, 32'h0}, {32'h5, 32'h1}, 100, -1);
        run_case(4, 1, 2, 2'b10, {32'h5, 32'h0}, {32'h5, 32'h1}, 100, -1);
        run_case(6, 1, 0, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, -1, -1);
        run_case(3, 1, 0, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, TIMEOUT - 1, -1);
        run_case(3, 1, 0, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, TIMEOUT, -1);
        run_case(DEPTH + 4, 0, 1, 2'b11, {32'h7, 32'h9}, {32'h7, 32'h9}, 10, -1);
        run_case(DEPTH, 1, 2, 2'b01, {32'h2, 32'h3}, {32'h7, 32'h3}, 25, -1);
        run_case(1, 1, 0, 2'b00, {32'hdead, 32'hbeef}, {32'h1, 32'h2}, 0, -1);
        run_case(5, 1, 0, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, -1, 30);
        run_case(7, 1, 1, 2'b11, {32'h5, 32'h1}, {32'h5, 32'h1}, 40, -1);

        // Randomized runs.
        for (int t = 0; t < 12; t++) begin
            trunc = ($urandom_range(0, 4) == 0);
            len   = trunc ? $urandom_range(DEPTH + 1, DEPTH + 8) : $urandom_range(1, DEPTH);
            e     = {$urandom, $urandom};
            r     = e;
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(0, 1) == 1)
                    r[ch*DATA_W +: DATA_W] = r[ch*DATA_W +: DATA_W] ^ (32'd1 << $urandom_range(0, 31));
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      k = -1;
            else if (sel == 1) k = TIMEOUT - 1 + $urandom_range(0, 1);
            else               k = $urandom_range(0, 80);
            run_case(len, !trunc, $urandom_range(0, 2), 2'($urandom_range(0, 3)), r, e, k, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
